// File: rtl/nasti_stream_writer.sv
// Stream-to-memory mover: consumes stream beats and writes them as INCR bursts on a NASTI write port.
// One burst outstanding at a time; a short stream is padded out with strobe-less beats to honour aw_len.
module nasti_stream_writer #(
    parameter int ADDR_WIDTH       = 64,
    parameter int DATA_WIDTH       = 64,
    parameter int DEST_WIDTH       = 1,
    parameter int USER_WIDTH       = 1,
    parameter int MAX_BURST_LENGTH = 8
) (
    input  logic                    aclk,
    input  logic                    areset,

    input  logic                    src_t_valid,
    output logic                    src_t_ready,
    input  logic [DATA_WIDTH-1:0]   src_t_data,
    input  logic [DATA_WIDTH/8-1:0] src_t_strb,
    input  logic [DATA_WIDTH/8-1:0] src_t_keep,
    input  logic                    src_t_last,
    input  logic [0:0]              src_t_id,
    input  logic [DEST_WIDTH-1:0]   src_t_dest,
    input  logic [USER_WIDTH-1:0]   src_t_user,

    output logic                    dest_aw_valid,
    input  logic                    dest_aw_ready,
    output logic [0:0]              dest_aw_id,
    output logic [ADDR_WIDTH-1:0]   dest_aw_addr,
    output logic [7:0]              dest_aw_len,
    output logic [2:0]              dest_aw_size,
    output logic [1:0]              dest_aw_burst,
    output logic                    dest_aw_lock,
    output logic [3:0]              dest_aw_cache,
    output logic [2:0]              dest_aw_prot,
    output logic [3:0]              dest_aw_qos,
    output logic [3:0]              dest_aw_region,
    output logic [0:0]              dest_aw_user,

    output logic                    dest_w_valid,
    input  logic                    dest_w_ready,
    output logic [DATA_WIDTH-1:0]   dest_w_data,
    output logic [DATA_WIDTH/8-1:0] dest_w_strb,
    output logic                    dest_w_last,
    output logic [0:0]              dest_w_user,

    input  logic                    dest_b_valid,
    output logic                    dest_b_ready,
    input  logic [0:0]              dest_b_id,
    input  logic [1:0]              dest_b_resp,
    input  logic [0:0]              dest_b_user,

    output logic                    dest_ar_valid,
    output logic                    dest_r_ready,

    input  logic                    c_valid,
    input  logic [ADDR_WIDTH-1:0]   c_addr,
    input  logic [ADDR_WIDTH-1:0]   c_len,
    output logic                    c_ready,

    output logic                    d_valid,
    output logic [ADDR_WIDTH-1:0]   d_count,
    output logic                    d_tlast,
    output logic                    d_err
);

    localparam int DATA_BYTE_CNT = DATA_WIDTH / 8;
    localparam int ADDR_SHIFT    = $clog2(DATA_BYTE_CNT);
    localparam int BCW           = $clog2(MAX_BURST_LENGTH + 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(ADDR_WIDTH'(DATA_BYTE_CNT - 1));

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_ADDR = 3'd1;
    localparam logic [2:0] S_DATA = 3'd2;
    localparam logic [2:0] S_RESP = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] len;
    logic [ADDR_WIDTH-1:0] count;
    logic                  tlast;
    logic                  err;
    logic [BCW-1:0]        beat_cnt;
    logic [BCW-1:0]        beats;
    logic [ADDR_WIDTH-1:0] len_beats;
    logic [ADDR_WIDTH-1:0] burst_bytes;
    logic [ADDR_WIDTH-1:0] c_len_aligned;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  src_hs;
    logic                  unused_inputs;

    assign unused_inputs = ^{src_t_strb, src_t_keep, src_t_id, src_t_dest, src_t_user,
                             dest_b_id, dest_b_user};

    always_comb begin
        len_beats = len >> ADDR_SHIFT;
        if (len_beats >= ADDR_WIDTH'(MAX_BURST_LENGTH))
            beats = BCW'(MAX_BURST_LENGTH);
        else
            beats = len_beats[BCW-1:0];
    end

    assign burst_bytes   = ADDR_WIDTH'(beats) << ADDR_SHIFT;
    assign c_len_aligned = c_len & ALIGN_MASK;

    assign c_ready = (state == S_IDLE);
    assign d_valid = (state == S_DONE);
    assign d_count = count;
    assign d_tlast = tlast;
    assign d_err   = err;

    assign dest_aw_valid  = (state == S_ADDR);
    assign dest_aw_id     = '0;
    assign dest_aw_addr   = addr;
    assign dest_aw_len    = 8'(beats - BCW'(1));
    assign dest_aw_size   = 3'(ADDR_SHIFT);
    assign dest_aw_burst  = 2'b01;
    assign dest_aw_lock   = 1'b0;
    assign dest_aw_cache  = '0;
    assign dest_aw_prot   = '0;
    assign dest_aw_qos    = '0;
    assign dest_aw_region = '0;
    assign dest_aw_user   = '0;

    // Once t_last has been taken the stream is left alone and the burst is filled with null beats.
    assign dest_w_valid = (state == S_DATA) && (tlast || src_t_valid);
    assign src_t_ready  = (state == S_DATA) && !tlast && dest_w_ready;
    assign dest_w_data  = tlast ? '0 : src_t_data;
    assign dest_w_strb  = tlast ? '0 : '1;
    assign dest_w_last  = (beat_cnt == BCW'(1));
    assign dest_w_user  = '0;

    assign dest_b_ready  = (state == S_RESP);
    assign dest_ar_valid = 1'b0;
    assign dest_r_ready  = 1'b0;

    assign aw_hs  = dest_aw_valid && dest_aw_ready;
    assign w_hs   = dest_w_valid && dest_w_ready;
    assign b_hs   = dest_b_valid && dest_b_ready;
    assign src_hs = src_t_valid && src_t_ready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state    <= S_IDLE;
            addr     <= '0;
            len      <= '0;
            count    <= '0;
            tlast    <= 1'b0;
            err      <= 1'b0;
            beat_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (c_valid) begin
                        addr  <= c_addr & ALIGN_MASK;
                        len   <= c_len_aligned;
                        count <= '0;
                        tlast <= 1'b0;
                        err   <= 1'b0;
                        state <= (c_len_aligned == '0) ? S_DONE : S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (aw_hs) begin
                        addr     <= addr + burst_bytes;
                        len      <= len - burst_bytes;
                        beat_cnt <= beats;
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt - BCW'(1);
                        if (src_hs) begin
                            count <= count + ADDR_WIDTH'(DATA_BYTE_CNT);
                            if (src_t_last)
                                tlast <= 1'b1;
                        end
                        if (beat_cnt == BCW'(1))
                            state <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (b_hs) begin
                        if (dest_b_resp != 2'b00)
                            err <= 1'b1;
                        state <= (len == '0 || tlast) ? S_DONE : S_ADDR;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nasti_stream_writer.sv
// Bench for nasti_stream_writer: randomized slave/stream models, a burst-level reference model
// and a scoreboard monitor that checks every aw, w and done event against queued expectations.
module tb_nasti_stream_writer;

    logic        aclk = 1'b0;
    logic        areset;
    always #5 aclk = ~aclk;

    logic        src_t_valid, src_t_ready, src_t_last;
    logic [63:0] src_t_data;
    logic [7:0]  src_t_strb, src_t_keep;
    logic [0:0]  src_t_id, src_t_dest, src_t_user;
    logic        dest_aw_valid, dest_aw_ready, dest_aw_lock;
    logic [0:0]  dest_aw_id, dest_aw_user, dest_w_user, dest_b_id, dest_b_user;
    logic [63:0] dest_aw_addr;
    logic [7:0]  dest_aw_len;
    logic [2:0]  dest_aw_size, dest_aw_prot;
    logic [1:0]  dest_aw_burst, dest_b_resp;
    logic [3:0]  dest_aw_cache, dest_aw_qos, dest_aw_region;
    logic        dest_w_valid, dest_w_ready, dest_w_last;
    logic [63:0] dest_w_data;
    logic [7:0]  dest_w_strb;
    logic        dest_b_valid, dest_b_ready, dest_ar_valid, dest_r_ready;
    logic        c_valid, c_ready, d_valid, d_tlast, d_err;
    logic [63:0] c_addr, c_len, d_count;

    nasti_stream_writer dut (
        .aclk(aclk), .areset(areset),
        .src_t_valid(src_t_valid), .src_t_ready(src_t_ready), .src_t_data(src_t_data),
        .src_t_strb(src_t_strb), .src_t_keep(src_t_keep), .src_t_last(src_t_last),
        .src_t_id(src_t_id), .src_t_dest(src_t_dest), .src_t_user(src_t_user),
        .dest_aw_valid(dest_aw_valid), .dest_aw_ready(dest_aw_ready), .dest_aw_id(dest_aw_id),
        .dest_aw_addr(dest_aw_addr), .dest_aw_len(dest_aw_len), .dest_aw_size(dest_aw_size),
        .dest_aw_burst(dest_aw_burst), .dest_aw_lock(dest_aw_lock), .dest_aw_cache(dest_aw_cache),
        .dest_aw_prot(dest_aw_prot), .dest_aw_qos(dest_aw_qos), .dest_aw_region(dest_aw_region),
        .dest_aw_user(dest_aw_user),
        .dest_w_valid(dest_w_valid), .dest_w_ready(dest_w_ready), .dest_w_data(dest_w_data),
        .dest_w_strb(dest_w_strb), .dest_w_last(dest_w_last), .dest_w_user(dest_w_user),
        .dest_b_valid(dest_b_valid), .dest_b_ready(dest_b_ready), .dest_b_id(dest_b_id),
        .dest_b_resp(dest_b_resp), .dest_b_user(dest_b_user),
        .dest_ar_valid(dest_ar_valid), .dest_r_ready(dest_r_ready),
        .c_valid(c_valid), .c_addr(c_addr), .c_len(c_len), .c_ready(c_ready),
        .d_valid(d_valid), .d_count(d_count), .d_tlast(d_tlast), .d_err(d_err)
    );

    typedef struct { logic [63:0] addr; logic [7:0] len; } aw_t;
    typedef struct { logic [63:0] data; logic [7:0] strb; logic last; } w_t;
    typedef struct { logic [63:0] count; logic tlast; logic err; } d_t;

    aw_t          exp_aw[$];
    w_t           exp_w[$];
    d_t           exp_d[$];
    logic [64:0]  src_q[$];
    logic [1:0]   bresp_q[$];
    logic [63:0]  mem [longint unsigned];

    int checks = 0, failures = 0;
    int stall = 0, src_hs_cnt = 0, done_cnt = 0, cycle = 0;
    int accept_cycle = 0, done_cycle = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic flag_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event expected=none", name);
    endtask

    // Stream source and NASTI slave with memory
    initial begin : bfm
        int          b_pend = 0, b_delay = 0, w_idx = 0;
        logic        src_held = 1'b0;
        logic [63:0] w_base[$];
        src_t_valid = 0; src_t_data = '0; src_t_last = 0;
        src_t_strb = '1; src_t_keep = '1; src_t_id = '0; src_t_dest = '0; src_t_user = '0;
        dest_aw_ready = 0; dest_w_ready = 0; dest_b_valid = 0; dest_b_resp = '0;
        dest_b_id = '0; dest_b_user = '0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                src_q.delete(); bresp_q.delete(); w_base.delete();
                b_pend = 0; b_delay = 0; w_idx = 0; src_held = 0;
                src_t_valid = 0; dest_aw_ready = 0; dest_w_ready = 0; dest_b_valid = 0;
                continue;
            end
            src_t_valid = (src_q.size() > 0) &&
                          (stall == 0 || src_held || $urandom_range(0, 2) != 0);
            if (src_q.size() > 0) begin
                src_t_data = src_q[0][63:0];
                src_t_last = src_q[0][64];
            end
            dest_aw_ready = (stall == 0) || ($urandom_range(0, 2) == 0);
            dest_w_ready  = (stall == 0) || ($urandom_range(0, 3) != 0);
            if (b_pend > 0 && b_delay == 0) begin
                dest_b_valid = 1;
                dest_b_resp  = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
            end else begin
                dest_b_valid = 0;
                if (b_delay > 0) b_delay--;
            end
            #1;
            if (src_t_valid && src_t_ready) begin
                void'(src_q.pop_front());
                src_hs_cnt++;
                src_held = 0;
            end else begin
                src_held = src_t_valid;
            end
            if (dest_aw_valid && dest_aw_ready) w_base.push_back(dest_aw_addr);
            if (dest_w_valid && dest_w_ready && w_base.size() > 0) begin
                if (dest_w_strb != 0)
                    mem[w_base[0] + 64'(w_idx * 8)] = dest_w_data;
                w_idx++;
                if (dest_w_last) begin
                    void'(w_base.pop_front());
                    w_idx = 0;
                    b_pend++;
                    b_delay = (stall != 0) ? $urandom_range(0, 3) : 0;
                end
            end
            if (dest_b_valid && dest_b_ready) begin
                b_pend--;
                if (bresp_q.size() > 0) void'(bresp_q.pop_front());
            end
        end
    end

    // Scoreboard monitor
    initial begin : monitor
        logic prev_d = 0;
        int   outstanding = 0, aw_cnt = 0, wlast_cnt = 0;
        aw_t  ea;
        w_t   ew;
        d_t   ed;
        forever begin
            @(negedge aclk);
            #2;
            cycle++;
            if (areset) begin
                exp_aw.delete(); exp_w.delete(); exp_d.delete();
                outstanding = 0; aw_cnt = 0; wlast_cnt = 0; prev_d = 0;
                continue;
            end
            if (prev_d) chk("d_valid_one_cycle", 64'(d_valid), 64'd0);
            if (c_valid && c_ready) accept_cycle = cycle;
            if (dest_aw_valid && dest_aw_ready) begin
                chk("aw_waits_for_prior_b", 64'(outstanding), 64'd0);
                if (exp_aw.size() == 0) flag_fail("aw_unexpected");
                else begin
                    ea = exp_aw.pop_front();
                    chk("aw_addr", dest_aw_addr, ea.addr);
                    chk("aw_len", 64'(dest_aw_len), 64'(ea.len));
                    chk("aw_size", 64'(dest_aw_size), 64'd3);
                    chk("aw_burst", 64'(dest_aw_burst), 64'd1);
                end
                outstanding++;
                aw_cnt++;
            end
            if (dest_w_valid && dest_w_ready) begin
                chk("w_after_aw", 64'(aw_cnt > wlast_cnt), 64'd1);
                if (exp_w.size() == 0) flag_fail("w_unexpected");
                else begin
                    ew = exp_w.pop_front();
                    chk("w_data", dest_w_data, ew.data);
                    chk("w_strb", 64'(dest_w_strb), 64'(ew.strb));
                    chk("w_last", 64'(dest_w_last), 64'(ew.last));
                end
                if (dest_w_last) wlast_cnt++;
            end
            if (dest_b_valid && dest_b_ready) outstanding--;
            if (d_valid) begin
                done_cycle = cycle;
                if (exp_d.size() == 0) flag_fail("done_unexpected");
                else begin
                    ed = exp_d.pop_front();
                    chk("d_count", d_count, ed.count);
                    chk("d_tlast", 64'(d_tlast), 64'(ed.tlast));
                    chk("d_err", 64'(d_err), 64'(ed.err));
                end
                done_cnt++;
            end
            prev_d = d_valid;
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_c_ready"}, 64'(c_ready), 64'd1);
        chk({tag, "_d_valid"}, 64'(d_valid), 64'd0);
        chk({tag, "_d_count"}, d_count, 64'd0);
        chk({tag, "_d_tlast"}, 64'(d_tlast), 64'd0);
        chk({tag, "_d_err"}, 64'(d_err), 64'd0);
        chk({tag, "_aw_valid"}, 64'(dest_aw_valid), 64'd0);
        chk({tag, "_w_valid"}, 64'(dest_w_valid), 64'd0);
        chk({tag, "_t_ready"}, 64'(src_t_ready), 64'd0);
    endtask

    // Reference model: walks the command as a sequence of bursts and predicts every event.
    task automatic run_cmd(input logic [63:0] addr, input logic [63:0] len, input int nsrc,
                           input int tlast_pos, input bit index_data,
                           input logic [1:0] br0, input logic [1:0] br1, input bit wait_done);
        logic [63:0] data[$];
        logic [63:0] a, l;
        int rem, b, k, burst, start;
        bit seen, err;
        logic [1:0] br;
        a = addr & ~64'h7;
        l = len & ~64'h7;
        for (int i = 0; i < nsrc; i++) data.push_back(index_data ? 64'(i) : {$urandom, $urandom});
        rem = int'(l >> 3); k = 0; burst = 0; seen = 0; err = 0;
        while (rem > 0) begin
            b = (rem > 8) ? 8 : rem;
            exp_aw.push_back('{addr: a, len: 8'(b - 1)});
            for (int i = 0; i < b; i++) begin
                if (seen) exp_w.push_back('{data: 64'd0, strb: 8'h00, last: (i == b - 1)});
                else begin
                    exp_w.push_back('{data: data[k], strb: 8'hff, last: (i == b - 1)});
                    if (k == tlast_pos - 1) seen = 1;
                    k++;
                end
            end
            br = (burst == 0) ? br0 : (burst == 1) ? br1 : 2'b00;
            if (br != 2'b00) err = 1;
            bresp_q.push_back(br);
            burst++;
            if (seen) break;
            a += 64'(b * 8);
            rem -= b;
        end
        exp_d.push_back('{count: 64'(k * 8), tlast: seen, err: err});
        for (int i = 0; i < nsrc; i++) src_q.push_back({(i == tlast_pos - 1), data[i]});
        src_hs_cnt = 0;
        start = done_cnt;
        c_addr = addr; c_len = len; c_valid = 1;
        @(negedge aclk);
        c_valid = 0;
        if (wait_done) begin
            for (int t = 0; t < 5000 && done_cnt == start; t++) @(negedge aclk);
            if (done_cnt == start) flag_fail("done_timeout");
            repeat (3) @(negedge aclk);
            #1;
            chk("src_consumed", 64'(src_hs_cnt), 64'(k));
            chk("src_left_unconsumed", 64'(src_q.size()), 64'(nsrc - k));
            chk("d_count_holds", d_count, 64'(k * 8));
            chk("c_ready_after_done", 64'(c_ready), 64'd1);
            chk("exp_w_drained", 64'(exp_w.size()), 64'd0);
            if (l == 0) chk("len0_latency", 64'((done_cycle - accept_cycle) <= 2), 64'd1);
            src_q.delete();
            bresp_q.delete();
        end
    endtask

    initial begin
        int nb, tp;
        logic [63:0] ra, rl;
        areset = 1; c_valid = 0; c_addr = '0; c_len = '0;
        repeat (3) @(negedge aclk);
        #1;
        check_reset_outputs("reset");
        chk("ar_valid_tied", 64'(dest_ar_valid), 64'd0);
        chk("r_ready_tied", 64'(dest_r_ready), 64'd0);
        @(negedge aclk);
        areset = 0;
        @(negedge aclk);

        run_cmd(64'h1000, 64'h40, 8, 8, 0, 2'b00, 2'b00, 1);
        run_cmd(64'h1000, 64'h98, 21, 0, 0, 2'b00, 2'b00, 1);
        run_cmd(64'h1000, 64'h40, 5, 3, 0, 2'b00, 2'b00, 1);
        run_cmd(64'h1000, 64'h0, 2, 0, 0, 2'b00, 2'b00, 1);

        stall = 1;
        run_cmd(64'h2000, 64'h80, 16, 0, 1, 2'b00, 2'b00, 1);
        for (int i = 0; i < 16; i++)
            chk("mem_beat", mem.exists(64'h2000 + 64'(i * 8)) ? mem[64'h2000 + 64'(i * 8)] : 64'hdead,
                64'(i));

        stall = 0;
        run_cmd(64'h4000, 64'h80, 16, 0, 0, 2'b10, 2'b00, 1);

        for (int it = 0; it < 6; it++) begin
            stall = $urandom_range(0, 1);
            ra = {48'd0, 4'($urandom_range(0, 15)), 12'd0} | 64'($urandom_range(0, 7));
            rl = 64'($urandom_range(0, 40) * 8 + $urandom_range(0, 7));
            nb = int'(rl >> 3);
            tp = $urandom_range(0, nb + 2);
            run_cmd(ra, rl, nb + 2, tp, 0, ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b00,
                    ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00, 1);
        end

        stall = 0;
        run_cmd(64'h3000, 64'h80, 16, 0, 0, 2'b00, 2'b00, 0);
        for (int t = 0; t < 200 && !dest_w_valid; t++) @(negedge aclk);
        chk("reached_data_beat", 64'(dest_w_valid), 64'd1);
        @(negedge aclk);
        areset = 1;
        @(negedge aclk);
        #1;
        check_reset_outputs("midcmd_reset");
        @(negedge aclk);
        areset = 0;
        @(negedge aclk);
        run_cmd(64'h5000, 64'h40, 8, 0, 0, 2'b00, 2'b00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
